// File: rtl/memory_pkg.sv
// Shared memory-map constants and the DMEM dump FSM state type.
package memory_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 16;
    localparam int unsigned IMEM_BYTES     = 32'h0000_1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dump_state_t;

endpackage

// File: rtl/dump_skid_fifo.sv
// Two-entry {addr, data} FIFO with a registered head; head drives the stream outputs.
module dump_skid_fifo #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [1:0]        count,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    logic [ADDR_W-1:0] tail_addr;
    logic [DATA_W-1:0] tail_data;
    logic              do_pop;

    assign do_pop    = pop && (count != 2'd0);
    assign out_valid = (count != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            out_addr  <= '0;
            out_data  <= '0;
            tail_addr <= '0;
            tail_data <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push && do_pop) begin
            if (count == 2'd2) begin
                out_addr  <= tail_addr;
                out_data  <= tail_data;
                tail_addr <= push_addr;
                tail_data <= push_data;
            end else begin
                out_addr <= push_addr;
                out_data <= push_data;
            end
        end else if (push) begin
            if (count == 2'd0) begin
                out_addr <= push_addr;
                out_data <= push_data;
            end else begin
                tail_addr <= push_addr;
                tail_data <= push_data;
            end
            count <= count + 2'd1;
        end else if (do_pop) begin
            out_addr <= tail_addr;
            out_data <= tail_data;
            count    <= count - 2'd1;
        end
    end

endmodule

// File: rtl/dmem_dump_reader.sv
// Sweeps a fixed DMEM word range through the read port and streams {addr, data}
// over valid/ready, with a 2-slot credit scheme so back-pressure never overflows.
module dmem_dump_reader
    import memory_pkg::*;
#(
    parameter int unsigned ADDR_W    = MEM_ADDR_WIDTH,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BASE_ADDR = IMEM_BYTES,
    parameter int unsigned NUM_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    localparam int unsigned      CNT_W    = $clog2(NUM_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    if ((NUM_WORDS < 1) || ((BASE_ADDR % 4) != 0) ||
        ((64'(BASE_ADDR) + 64'(4) * 64'(NUM_WORDS - 1)) >= (64'(1) << ADDR_W))) begin : g_param_check
        $error("dmem_dump_reader: BASE_ADDR/NUM_WORDS range invalid for ADDR_W");
    end

    dump_state_t       state, state_next;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] pend_addr;
    logic [CNT_W-1:0]  issued;
    logic              inflight;
    logic [1:0]        fifo_count;
    logic              pop;
    logic [2:0]        occupancy;

    assign pop      = out_valid && out_ready;
    assign mem_addr = rd_ptr;
    // Credit counts the slot freed by a same-cycle transfer, which is what sustains 1 word/cycle.
    assign occupancy = 3'(fifo_count) + 3'(inflight) - 3'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:  if (start) state_next = READ;
                READ:  if (mem_rd_en && (issued == LAST_IDX)) state_next = DRAIN;
                // Leave as the FIFO becomes empty so done lands the cycle after the last transfer.
                DRAIN: if (!inflight && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop)))
                           state_next = DONE;
                DONE:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_rd_en = 1'b0;
        case (state)
            READ: begin
                busy      = 1'b1;
                mem_rd_en = !abort && (occupancy < 3'd2);
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            pend_addr <= '0;
            issued    <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= mem_rd_en;
            if (mem_rd_en) begin
                pend_addr <= rd_ptr;
                rd_ptr    <= rd_ptr + ADDR_W'(4);
                issued    <= issued + CNT_W'(1);
            end else if ((state == IDLE) && start && !abort) begin
                rd_ptr <= ADDR_W'(BASE_ADDR);
                issued <= '0;
            end
        end
    end

    dump_skid_fifo #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_addr (pend_addr),
        .push_data (mem_rd_data),
        .pop       (pop),
        .flush     (abort),
        .count     (fifo_count),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_data  (out_data)
    );

endmodule
